bl_frame_scheduler: RTL and testbench

- Collects the per-block luminance means produced by the block-mean stage into a ping-pong frame buffer, one mean per block, BLK_COLS x BLK_ROWS blocks per frame.
- At each frame boundary (vs rising edge) it validates the captured frame, swaps banks and streams the completed frame out over a valid/ready interface.
- It sits between the block-mean stage and the backlight LED driver, and is the only sequencer of the buffer.

---
 rtl/bl_frame_scheduler.sv | 153 +++++++++++++++
 tb/tb_bl_frame_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bl_frame_scheduler.sv
// Ping-pong block-mean frame buffer: captures one frame of block means while the
// previously completed frame is streamed to the LED driver over valid/ready.
module bl_frame_scheduler #(
    parameter int BLK_COLS = 40,
    parameter int BLK_ROWS = 20,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic [DW-1:0] mean_in,
    input  logic          mean_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          busy,
    output logic          frame_err,
    output logic          overrun
);
    localparam int N  = BLK_COLS * BLK_ROWS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    logic          vs_q;
    logic          vs_rise;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          excess_q, excess_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic          wr_accept;
    logic          wr_extra;
    logic [CW-1:0] cnt_incl;
    logic          excess_incl;
    logic          frame_good;
    logic          swap;
    logic [DW-1:0] rd_word [2];

    assign vs_rise = vs & ~vs_q;

    // A write coincident with vs_rise still belongs to the closing frame.
    assign wr_accept   = mean_valid && (wr_cnt_q != N_C);
    assign wr_extra    = mean_valid && (wr_cnt_q == N_C);
    assign cnt_incl    = wr_cnt_q + CW'(wr_accept);
    assign excess_incl = excess_q | wr_extra;
    assign frame_good  = (cnt_incl == N_C) && !excess_incl;
    assign swap        = vs_rise && frame_good && (state_q == ST_IDLE);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [DW-1:0] mem [N];
        logic [DW-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_accept && (wr_bank_q == 1'(gi))) begin
                mem[wr_cnt_q] <= mean_in;
            end
            if (state_q == ST_FETCH) begin
                rd_q <= mem[rd_idx_q];
            end
        end

        assign rd_word[gi] = rd_q;
    end

    always_comb begin
        wr_cnt_d    = cnt_incl;
        excess_d    = excess_incl;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (vs_rise) begin
            wr_cnt_d    = '0;
            excess_d    = 1'b0;
            frame_err_d = !frame_good;
            overrun_d   = frame_good && (state_q != ST_IDLE);
            if (swap) begin
                rd_bank_d = wr_bank_q;
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (swap) begin
                    state_d  = ST_FETCH;
                    rd_idx_d = '0;
                end
            end
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + CW'(1);
                        state_d  = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q        <= 1'b0;
            wr_cnt_q    <= '0;
            excess_q    <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            state_q     <= ST_IDLE;
            rd_idx_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            vs_q        <= vs;
            wr_cnt_q    <= wr_cnt_d;
            excess_q    <= excess_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // The read register only updates in FETCH, so data holds steady through a stall.
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_valid ? rd_word[rd_bank_q] : '0;
    assign out_first = out_valid && (rd_idx_q == '0);
    assign out_last  = out_valid && (rd_idx_q == LAST_C);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_bl_frame_scheduler.sv
// Randomized bench for bl_frame_scheduler: frames are modelled as queues of means,
// closed on vs edges and compared beat-by-beat against the streamed output.
module tb_bl_frame_scheduler;
    localparam int BLK_COLS = 40;
    localparam int BLK_ROWS = 20;
    localparam int DW       = 8;
    localparam int N        = BLK_COLS * BLK_ROWS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vs = 1'b0;
    logic [DW-1:0] mean_in = '0;
    logic          mean_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_first;
    logic          out_last;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    always #5 clk = ~clk;

    bl_frame_scheduler #(
        .BLK_COLS(BLK_COLS),
        .BLK_ROWS(BLK_ROWS),
        .DW(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vs(vs),
        .mean_in(mean_in),
        .mean_valid(mean_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_first(out_first),
        .out_last(out_last),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] frm[$];
    logic [DW-1:0] exp_q[$];
    bit            excess = 1'b0;
    bit            rd_active = 1'b0;
    int            beat = 0;
    bit            exp_err = 1'b0;
    bit            exp_ovr = 1'b0;
    bit            vs_prev = 1'b0;
    bit            stalled = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int            ready_pol = 0;   // 0: always ready, 1: random, 2: never ready

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic cycle(input bit v, input bit mv, input logic [DW-1:0] m, input bit do_rst);
        bit rdy;
        bit act0;
        bit good;
        @(negedge clk);
        check("frame_err", frame_err, exp_err);
        check("overrun", overrun, exp_ovr);
        check("busy", busy, rd_active);
        if (!rd_active) check("idle_valid", out_valid, 0);
        if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, stall_data);
        end
        rdy = (ready_pol == 0) ? 1'b1 : (ready_pol == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        rst        = do_rst;
        vs         = v;
        mean_valid = mv;
        mean_in    = m;
        out_ready  = rdy;
        exp_err = 1'b0;
        exp_ovr = 1'b0;
        stalled = 1'b0;
        if (do_rst) begin
            rd_active = 1'b0;
            exp_q.delete();
            frm.delete();
            excess  = 1'b0;
            vs_prev = 1'b0;
            beat    = 0;
        end else begin
            act0 = rd_active;
            if (out_valid && rdy && exp_q.size() > 0) begin
                check("data", out_data, exp_q[0]);
                check("first", out_first, beat == 0);
                check("last", out_last, beat == N - 1);
                void'(exp_q.pop_front());
                beat++;
                if (beat == N) rd_active = 1'b0;
            end else if (out_valid) begin
                stalled    = 1'b1;
                stall_data = out_data;
            end
            if (mv) begin
                if (frm.size() < N) frm.push_back(m);
                else excess = 1'b1;
            end
            if (v && !vs_prev) begin
                good = (frm.size() == N) && !excess;
                $display("[%0t] frame close: means=%0d excess=%0b -> %s", $time, frm.size(), excess,
                         good ? (act0 ? "overrun" : "swap") : "error");
                if (good && !act0) begin
                    exp_q     = frm;
                    rd_active = 1'b1;
                    beat      = 0;
                end else if (good) begin
                    exp_ovr = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
                frm.delete();
                excess = 1'b0;
            end
            vs_prev = v;
        end
    endtask

    task automatic send_frame(input int count, input bit idx_data, input bit vs_on_last);
        int i = 0;
        logic [DW-1:0] d;
        while (i < count) begin
            if ($urandom_range(0, 3) != 0) begin
                d = idx_data ? DW'(i) : DW'($urandom);
                cycle(vs_on_last && (i == count - 1), 1'b1, d, 1'b0);
                i++;
            end else begin
                cycle(1'b0, 1'b0, '0, 1'b0);
            end
        end
        if (!vs_on_last) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain(input int stall_at, input int pol);
        int n = 0;
        int left = 50;
        while (rd_active && n < 10 * N) begin
            if (stall_at >= 0 && beat == stall_at && left > 0) begin
                ready_pol = 2;
                left--;
            end else begin
                ready_pol = pol;
            end
            cycle(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        check("drain_done", rd_active, 0);
        ready_pol = pol;
    endtask

    initial begin
        int n;
        ready_pol = 0;
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_first", out_first, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        check("rst_ovr", overrun, 0);

        // Index-pattern frame with continuous ready
        send_frame(N, 1'b1, 1'b0);
        drain(-1, 0);
        // Short frame, then a good one
        send_frame(N - 1, 1'b0, 1'b0);
        send_frame(N, 1'b0, 1'b0);
        drain(-1, 0);
        // Over-long frame, then a good one with random ready
        send_frame(N + 1, 1'b0, 1'b0);
        send_frame(N, 1'b0, 1'b0);
        drain(-1, 1);
        // Backpressure for 50 cycles at beat 10
        send_frame(N, 1'b1, 1'b0);
        drain(10, 0);
        // Second good frame while first is stalled, then a third after readout
        ready_pol = 2;
        send_frame(N, 1'b0, 1'b0);
        send_frame(N, 1'b0, 1'b0);
        drain(-1, 1);
        send_frame(N, 1'b0, 1'b0);
        drain(-1, 1);
        // Final mean coincident with vs
        ready_pol = 0;
        send_frame(N, 1'b0, 1'b1);
        drain(-1, 0);
        // Reset mid-readout at beat 300
        send_frame(N, 1'b0, 1'b0);
        n = 0;
        while (rd_active && beat < 300 && n < 4 * N) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        check("rst_beat", beat, 300);
        cycle(1'b0, 1'b0, '0, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, '0, 1'b0);
        send_frame(N, 1'b0, 1'b0);
        drain(-1, 0);
        // Random mix of frame lengths, ready behaviour and vs alignment
        for (int f = 0; f < 4; f++) begin
            ready_pol = int'($urandom_range(0, 1));
            send_frame(N - 1 + int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)));
        end
        drain(-1, 1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
